// File: rtl/particle_stream_writer.sv
// Streams NUM_PARTICLES words per frame from a valid/ready source into a particle buffer
// write port, counting completed frames.
module particle_stream_writer #(
  parameter int unsigned RAM_WIDTH     = 18,
  parameter int unsigned RAM_DEPTH     = 1024,
  parameter int unsigned NUM_PARTICLES = 1024,
  localparam int unsigned AW           = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 start_in,
  input  logic                 s_valid_in,
  input  logic [RAM_WIDTH-1:0] s_data_in,
  output logic                 s_ready_out,
  output logic [AW-1:0]        addr_out,
  output logic [RAM_WIDTH-1:0] data_out,
  output logic                 we_out,
  output logic                 en_out,
  output logic                 busy_out,
  output logic                 frame_done_out,
  output logic [15:0]          frame_count_out
);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  localparam logic [AW-1:0] LastIdx = AW'(NUM_PARTICLES - 1);

  state_e               state_q, state_d;
  logic [AW-1:0]        index_q, index_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [RAM_WIDTH-1:0] data_q, data_d;
  logic                 we_q, we_d;
  logic                 done_q, done_d;
  logic [15:0]          count_q, count_d;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          state_d = StWrite;
          index_d = '0;
        end
      end
      StWrite: begin
        // Write port is registered: the accepted word appears on the next cycle.
        if (s_valid_in) begin
          we_d   = 1'b1;
          addr_d = index_q;
          data_d = s_data_in;
          if (index_q == LastIdx) begin
            state_d = StDone;
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        done_d  = 1'b1;
        count_d = count_q + 16'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
      index_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign s_ready_out     = (state_q == StWrite);
  assign busy_out        = (state_q == StWrite) || (state_q == StDone);
  assign addr_out        = addr_q;
  assign data_out        = data_q;
  assign we_out          = we_q;
  assign en_out          = we_q;
  assign frame_done_out  = done_q;
  assign frame_count_out = count_q;

endmodule

// File: tb/tb_particle_stream_writer.sv
// Bench for particle_stream_writer: frame-level model checked every cycle, directed scenarios,
// and a NUM_PARTICLES=1 instance run through a full frame-counter wrap.
module tb_particle_stream_writer;

  localparam int unsigned W   = 18;
  localparam int unsigned NUM = 4;
  localparam int unsigned AW  = 4;

  logic          clk;
  logic          rst_n, start, valid;
  logic [W-1:0]  data;
  logic          ready, we, en, busy, fdone;
  logic [AW-1:0] addr;
  logic [W-1:0]  wdata;
  logic [15:0]   fcount;

  logic          rst1_n, start1, valid1;
  logic [W-1:0]  data1;
  logic          ready1, we1, en1, busy1, fdone1;
  logic [0:0]    addr1;
  logic [W-1:0]  wdata1;
  logic [15:0]   fcount1;

  particle_stream_writer #(.RAM_WIDTH(W), .RAM_DEPTH(16), .NUM_PARTICLES(NUM)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .s_valid_in(valid), .s_data_in(data),
    .s_ready_out(ready), .addr_out(addr), .data_out(wdata), .we_out(we), .en_out(en),
    .busy_out(busy), .frame_done_out(fdone), .frame_count_out(fcount)
  );

  particle_stream_writer #(.RAM_WIDTH(W), .RAM_DEPTH(1), .NUM_PARTICLES(1)) dut1 (
    .clk_in(clk), .rst_n_in(rst1_n), .start_in(start1), .s_valid_in(valid1), .s_data_in(data1),
    .s_ready_out(ready1), .addr_out(addr1), .data_out(wdata1), .we_out(we1), .en_out(en1),
    .busy_out(busy1), .frame_done_out(fdone1), .frame_count_out(fcount1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic wrap_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Frame-level model: in_frame = accepting words, fin = last word presented, pulse next.
  logic        m_in = 0, m_fin = 0, m_we = 0, m_done = 0;
  int          m_words = 0;
  int          m_addr = 0;
  logic [W-1:0] m_data = '0;
  logic [15:0] m_cnt = '0;

  int wl_addr[$];
  int wl_data[$];
  int wl_cyc[$];
  int done_cyc[$];

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_in = 0; m_fin = 0; m_words = 0; m_we = 0; m_addr = 0; m_data = '0;
        m_done = 0; m_cnt = '0;
      end else begin
        m_we = 0;
        m_done = 0;
        if (m_fin) begin
          m_fin = 0;
          m_done = 1;
          m_cnt = m_cnt + 16'd1;
        end else if (m_in) begin
          if (valid) begin
            m_we = 1;
            m_addr = m_words;
            m_data = data;
            m_words++;
            if (m_words == NUM) begin
              m_in = 0;
              m_fin = 1;
            end
          end
        end else if (start) begin
          m_in = 1;
          m_words = 0;
        end
      end
      #1;
      chk("we", {31'd0, we}, {31'd0, m_we});
      chk("en", {31'd0, en}, {31'd0, m_we});
      chk("addr", {28'd0, addr}, m_addr);
      chk("data", {14'd0, wdata}, {14'd0, m_data});
      chk("ready", {31'd0, ready}, {31'd0, m_in});
      chk("busy", {31'd0, busy}, {31'd0, m_in | m_fin});
      chk("frame_done", {31'd0, fdone}, {31'd0, m_done});
      chk("frame_count", {16'd0, fcount}, {16'd0, m_cnt});
      if (we === 1'b1) begin
        wl_addr.push_back(int'(addr));
        wl_data.push_back(int'(wdata));
        wl_cyc.push_back(cyc);
      end
      if (fdone === 1'b1) done_cyc.push_back(cyc);
    end
  end

  task automatic step(input logic st, input logic v, input logic [W-1:0] d);
    start = st;
    valid = v;
    data  = d;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    wl_addr.delete();
    wl_data.delete();
    wl_cyc.delete();
    done_cyc.delete();
  endtask

  // ed[i] < 0 means the data value is not pinned.
  task automatic chk_log(input string nm, input int n, input int ea[8], input int ed[8]);
    chk({nm, " nwrites"}, wl_addr.size(), n);
    if (wl_addr.size() == n) begin
      for (int i = 0; i < n; i++) begin
        chk($sformatf("%s addr%0d", nm, i), wl_addr[i], ea[i]);
        if (ed[i] >= 0) chk($sformatf("%s data%0d", nm, i), wl_data[i], ed[i]);
      end
    end
  endtask

  int ea[8];
  int ed[8];

  initial begin
    rst_n = 1'b0;
    start = 1'b0; valid = 1'b0; data = '0;
    @(negedge clk);
    step(0, 0, 0);
    rst_n = 1'b1;
    chk("reset ready", {31'd0, ready}, 0);
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset count", {16'd0, fcount}, 0);

    // Full frame with continuous valid.
    clear_logs();
    step(1, 0, 0);
    step(0, 1, 'h11); step(0, 1, 'h22); step(0, 1, 'h33); step(0, 1, 'h44);
    repeat (3) step(0, 0, 0);
    ea = '{0, 1, 2, 3, 0, 0, 0, 0};
    ed = '{'h11, 'h22, 'h33, 'h44, 0, 0, 0, 0};
    chk_log("full", 4, ea, ed);
    chk("full npulse", done_cyc.size(), 1);
    if (done_cyc.size() == 1 && wl_cyc.size() == 4)
      chk("full pulse latency", done_cyc[0] - wl_cyc[3], 1);
    if (wl_cyc.size() == 4) chk("full consecutive", wl_cyc[3] - wl_cyc[0], 3);
    chk("full count", {16'd0, fcount}, 1);

    // Backpressure gaps: valid 1,0,0,1,1,0,1.
    clear_logs();
    step(1, 0, 0);
    step(0, 1, 'hA0); step(0, 0, 'hA1); step(0, 0, 'hA2); step(0, 1, 'hA3);
    step(0, 1, 'hA4); step(0, 0, 'hA5); step(0, 1, 'hA6);
    repeat (3) step(0, 0, 0);
    ea = '{0, 1, 2, 3, 0, 0, 0, 0};
    ed = '{'hA0, 'hA3, 'hA4, 'hA6, 0, 0, 0, 0};
    chk_log("gaps", 4, ea, ed);
    chk("gaps npulse", done_cyc.size(), 1);
    chk("gaps count", {16'd0, fcount}, 2);

    // Start asserted again mid-frame is ignored.
    clear_logs();
    step(1, 0, 0);
    step(0, 1, 1); step(0, 1, 2); step(1, 0, 0); step(1, 1, 3); step(1, 1, 4);
    repeat (3) step(0, 0, 0);
    ea = '{0, 1, 2, 3, 0, 0, 0, 0};
    ed = '{1, 2, 3, 4, 0, 0, 0, 0};
    chk_log("restart", 4, ea, ed);
    chk("restart npulse", done_cyc.size(), 1);
    chk("restart count", {16'd0, fcount}, 3);

    // Back-to-back frames with start held, from a fresh reset.
    rst_n = 1'b0;
    step(0, 0, 0);
    rst_n = 1'b1;
    clear_logs();
    for (int k = 0; k < 40 && done_cyc.size() < 2; k++) step(1, 1, W'('h100 + k));
    repeat (2) step(0, 0, 0);
    ea = '{0, 1, 2, 3, 0, 1, 2, 3};
    ed = '{-1, -1, -1, -1, -1, -1, -1, -1};
    chk_log("b2b", 8, ea, ed);
    chk("b2b npulse", done_cyc.size(), 2);
    if (wl_cyc.size() == 8) chk("b2b frame gap", wl_cyc[4] - wl_cyc[3], 3);
    chk("b2b count", {16'd0, fcount}, 2);

    // Reset mid-frame, with start and a handshake on the reset edge.
    clear_logs();
    step(1, 0, 0);
    step(0, 1, 5); step(0, 1, 6);
    rst_n = 1'b0;
    step(1, 1, 7);
    rst_n = 1'b1;
    chk("rst we", {31'd0, we}, 0);
    chk("rst addr", {28'd0, addr}, 0);
    chk("rst data", {14'd0, wdata}, 0);
    chk("rst count", {16'd0, fcount}, 0);
    chk("rst ready", {31'd0, ready}, 0);
    chk("rst busy", {31'd0, busy}, 0);
    repeat (4) step(0, 0, 0);
    chk("rst nwrites", wl_addr.size(), 2);
    chk("rst npulse", done_cyc.size(), 0);
    clear_logs();
    step(1, 0, 0);
    step(0, 1, 8); step(0, 1, 9); step(0, 1, 10); step(0, 1, 11);
    repeat (3) step(0, 0, 0);
    ea = '{0, 1, 2, 3, 0, 0, 0, 0};
    ed = '{8, 9, 10, 11, 0, 0, 0, 0};
    chk_log("after rst", 4, ea, ed);
    chk("after rst count", {16'd0, fcount}, 1);

    wait (wrap_done);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Single-word frames run continuously until the 16-bit frame counter wraps.
  initial begin
    int   pulses, writes, bad_addr, late;
    int   p1_cyc, p2_cyc;
    logic prev_we;
    rst1_n = 1'b0; start1 = 1'b1; valid1 = 1'b1; data1 = W'(3);
    repeat (2) @(negedge clk);
    rst1_n = 1'b1;
    pulses = 0; writes = 0; bad_addr = 0; late = 0; prev_we = 1'b0;
    p1_cyc = 0; p2_cyc = 0;
    for (int c = 0; c < 200000 && pulses < 65536; c++) begin
      @(posedge clk);
      #1;
      if (we1 === 1'b1) begin
        writes++;
        if (addr1 !== 1'b0) bad_addr++;
      end
      if (fdone1 === 1'b1) begin
        pulses++;
        if (!prev_we) late++;
        if (pulses == 1) begin
          p1_cyc = c;
          chk("n1 first count", {16'd0, fcount1}, 1);
        end
        if (pulses == 2) p2_cyc = c;
        if (pulses == 65535) chk("n1 count ffff", {16'd0, fcount1}, 'hFFFF);
      end
      prev_we = we1;
    end
    chk("n1 pulses", pulses, 65536);
    chk("n1 writes", writes, 65536);
    chk("n1 count wrap", {16'd0, fcount1}, 0);
    chk("n1 addr nonzero", bad_addr, 0);
    chk("n1 pulse not after write", late, 0);
    chk("n1 frame period", p2_cyc - p1_cyc, 3);
    wrap_done = 1'b1;
  end

endmodule

// File: doc/particle_stream_writer.md
PARTICLE_STREAM_WRITER -- requirements
Module: particle_stream_writer

Interface
REQ-001 The block SHALL have parameter RAM_WIDTH, default 18, particle word width in bits.
REQ-002 The block SHALL have parameter RAM_DEPTH, default 1024, entries in the target particle buffer.
REQ-003 The block SHALL have parameter NUM_PARTICLES, default 1024, words written per frame; legal range 1..RAM_DEPTH.
REQ-004 The block SHALL define AW = ceil(log2(RAM_DEPTH)), minimum 1, as the address width.
REQ-005 The block SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n_in, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port start_in, input, 1 bit: request to begin a frame.
REQ-008 The block SHALL have port s_valid_in, input, 1 bit: upstream particle word valid.
REQ-009 The block SHALL have port s_data_in, input, RAM_WIDTH bits: upstream particle word.
REQ-010 The block SHALL have port s_ready_out, output, 1 bit: block accepts a word this cycle.
REQ-011 The block SHALL have port addr_out, output, AW bits: buffer write address.
REQ-012 The block SHALL have port data_out, output, RAM_WIDTH bits: buffer write data.
REQ-013 The block SHALL have port we_out, output, 1 bit: buffer write enable.
REQ-014 The block SHALL have port en_out, output, 1 bit: buffer port enable, equal to we_out.
REQ-015 The block SHALL have port busy_out, output, 1 bit: high while state is WRITE or DONE.
REQ-016 The block SHALL have port frame_done_out, output, 1 bit: one-cycle pulse marking a completed frame.
REQ-017 The block SHALL have port frame_count_out, output, 16 bits: number of completed frames.

Function
REQ-018 The block SHALL implement the states IDLE, WRITE and DONE.
REQ-019 In IDLE, the block SHALL move to WRITE on start_in=1 and clear its internal word index to 0.
REQ-020 s_ready_out SHALL be 1 exactly when the state is WRITE; it is a combinational function of the state register only.
REQ-021 A handshake SHALL occur on an edge where s_valid_in=1 and s_ready_out=1; no other edge accepts a word.
REQ-022 On the edge after a handshake, the block SHALL drive we_out=1, addr_out=index and data_out=s_data_in, all registered, for exactly one cycle.
REQ-023 The block SHALL then increment the index; write latency is 1 cycle.
REQ-024 When s_valid_in=0 in WRITE, the block SHALL drive we_out=0 and hold addr_out and data_out at their last values.
REQ-025 On the handshake with index = NUM_PARTICLES-1, the block SHALL enter DONE on that edge, so s_ready_out=0 during the cycle in which the last write is presented.
REQ-026 From DONE, on the next edge the block SHALL go to IDLE, pulse frame_done_out=1 for one cycle and increment frame_count_out.
REQ-027 frame_done_out SHALL therefore be asserted one cycle after the last we_out.
REQ-028 frame_count_out SHALL wrap from 0xFFFF to 0x0000.
REQ-029 The index SHALL never exceed NUM_PARTICLES-1, addr_out SHALL never reach RAM_DEPTH, and each frame SHALL restart at address 0.
REQ-030 The block SHALL ignore start_in while in WRITE or DONE; no restart and no index change.
REQ-031 When start_in=1 in the IDLE cycle that carries the frame_done_out pulse, the block SHALL enter WRITE on the next edge (back-to-back frames).
REQ-032 When NUM_PARTICLES=1, the sequence SHALL be IDLE -> WRITE -> DONE -> IDLE with exactly one write.
REQ-033 The block SHALL not drive data_out combinationally from s_data_in.

Reset
REQ-034 On an edge with rst_n_in=0, the block SHALL set state=IDLE, index=0, addr_out=0, data_out=0, we_out=0, en_out=0, frame_done_out=0 and frame_count_out=0; busy_out and s_ready_out are then 0.
REQ-035 A reset mid-frame SHALL abandon the frame with no further writes and no frame_done_out pulse; words already written are not undone.
REQ-036 Reset SHALL take priority over start_in and any handshake on the same edge.

Verification
REQ-037 Full frame (NUM_PARTICLES=4), s_valid_in held 1 with data 0x11, 0x22, 0x33, 0x44 -> writes at addresses 0..3 on 4 consecutive cycles, frame_done_out pulses the cycle after address 3, frame_count_out=1.
REQ-038 Backpressure gaps: valid pattern 1,0,0,1,1,0,1 -> exactly 4 writes, addresses 0..3 in order, we_out=0 in the gap cycles, addr_out held through gaps.
REQ-039 Start during a frame: start_in=1 again after 2 words -> index continues at 2, exactly one frame_done_out pulse.
REQ-040 Reset mid-frame: rst_n_in=0 after 2 writes -> all outputs 0, no frame_done_out; a following start writes again from address 0.
REQ-041 Back-to-back frames: start_in held 1 for 2 frames -> addresses 0..3 then 0..3, two pulses, frame_count_out=2, s_ready_out low only in DONE and the IDLE cycle.
REQ-042 Frame counter wrap: preload via 65536 frames of NUM_PARTICLES=1 -> frame_count_out returns to 0x0000.
